// File: rtl/knn_pkg.sv
// knn_pkg: entry layout, invalid-distance fill and FSM states shared by the kNN blocks.
package knn_pkg;
  localparam int DIST_W = 32;
  localparam int LABEL_W = 8;
  localparam int ENTRY_W = DIST_W + LABEL_W;
  localparam logic [DIST_W-1:0] INVALID_DIST = '1;
  typedef enum logic [1:0] {IDLE, SCAN, PICK, DONE} state_e;
  function automatic int vote_w(input int k);
    return $clog2(k + 1);
  endfunction
endpackage

// File: rtl/knn_label_hist.sv
// knn_label_hist: M per-class vote counters with clear, indexed increment and indexed read.
module knn_label_hist #(
  parameter int M = 10,
  parameter int C = 8,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [C-1:0]  inc_idx_i,
  input  logic [C-1:0]  rd_idx_i,
  output logic [VW-1:0] rd_cnt_o
);
  logic [VW-1:0] cnt_q [M];
  always_ff @(posedge clk) begin
    for (int k = 0; k < M; k++) begin
      if (!rst || clr_i) cnt_q[k] <= '0;
      else if (inc_i && inc_idx_i == C'(k)) cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end
  // Out-of-range indices read as zero so an illegal nearest label never wins on count.
  always_comb begin
    rd_cnt_o = '0;
    for (int k = 0; k < M; k++) rd_cnt_o = (rd_idx_i == C'(k)) ? cnt_q[k] : rd_cnt_o;
  end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: snapshots the sorted neighbour list, tallies valid labels and returns the
// majority class (ties to the nearest neighbour's class) through a valid/ready handshake.
module knn_vote
  import knn_pkg::*;
#(
  parameter int DATA_W = DIST_W,
  parameter int C = LABEL_W,
  parameter int K = 4,
  parameter int M = 10,
  parameter int data_info = DATA_W + C,
  localparam int VOTE_W = vote_w(K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K*data_info-1:0] nb_list,
  output logic                   busy,
  output logic                   valid,
  input  logic                   ready,
  output logic [C-1:0]           label_out,
  output logic [VOTE_W-1:0]      votes_out,
  output logic                   empty,
  output logic                   bad_label
);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = $clog2(M + 1);
  state_e state_q, state_d;
  logic [K*data_info-1:0] snap_q, snap_d;
  logic [IW-1:0] i_q, i_d;
  logic [PW-1:0] p_q, p_d;
  logic [C-1:0] near_q, near_d, best_q, best_d, label_q, label_d;
  logic [VOTE_W-1:0] best_cnt_q, best_cnt_d, votes_q, votes_d;
  logic found_q, found_d, bad_q, bad_d, empty_q, empty_d, bad_out_q, bad_out_d;
  logic [DATA_W-1:0] ent_dist;
  logic [C-1:0] ent_label, cls, rd_idx, pick_label;
  logic [VOTE_W-1:0] rd_cnt, pick_cnt;
  logic ent_ok, legal, take;
  // The snapshot shifts left each SCAN cycle, so the current entry is always at the top.
  assign ent_dist = snap_q[K*data_info-1 -: DATA_W];
  assign ent_label = snap_q[K*data_info-DATA_W-1 -: C];
  assign ent_ok = ~&ent_dist;
  assign legal = ent_label < C'(M);
  // PICK step 0 seeds the best with the nearest label; step p compares class p-1.
  assign cls = C'(p_q - 1'b1);
  assign rd_idx = (p_q == '0) ? near_q : cls;
  assign take = (p_q != '0) && (rd_cnt > best_cnt_q);
  assign pick_label = (p_q == '0) ? near_q : take ? cls : best_q;
  assign pick_cnt = ((p_q == '0) || take) ? rd_cnt : best_cnt_q;
  assign busy = state_q != IDLE;
  assign valid = state_q == DONE;
  assign label_out = label_q;
  assign votes_out = votes_q;
  assign empty = empty_q;
  assign bad_label = bad_out_q;
  knn_label_hist #(.M(M), .C(C), .VW(VOTE_W)) u_hist (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == IDLE && start),
    .inc_i(state_q == SCAN && ent_ok && legal),
    .inc_idx_i(ent_label),
    .rd_idx_i(rd_idx),
    .rd_cnt_o(rd_cnt)
  );
  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    i_d = i_q;
    p_d = p_q;
    near_d = near_q;
    found_d = found_q;
    bad_d = bad_q;
    best_d = best_q;
    best_cnt_d = best_cnt_q;
    label_d = label_q;
    votes_d = votes_q;
    empty_d = empty_q;
    bad_out_d = bad_out_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        snap_d = nb_list;
        i_d = '0;
        near_d = '0;
        found_d = 1'b0;
        bad_d = 1'b0;
      end
      SCAN: begin
        snap_d = snap_q << data_info;
        i_d = i_q + 1'b1;
        bad_d = bad_q | (ent_ok & ~legal);
        near_d = (ent_ok && !found_q) ? ent_label : near_q;
        found_d = found_q | ent_ok;
        if (i_q == IW'(K - 1)) begin
          state_d = PICK;
          p_d = '0;
        end
      end
      PICK: begin
        best_d = pick_label;
        best_cnt_d = pick_cnt;
        p_d = p_q + 1'b1;
        if (p_q == PW'(M)) begin
          state_d = DONE;
          label_d = pick_label;
          votes_d = pick_cnt;
          empty_d = ~found_q;
          bad_out_d = bad_q;
        end
      end
      DONE: if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      snap_q <= '0;
      i_q <= '0;
      p_q <= '0;
      near_q <= '0;
      found_q <= 1'b0;
      bad_q <= 1'b0;
      best_q <= '0;
      best_cnt_q <= '0;
      label_q <= '0;
      votes_q <= '0;
      empty_q <= 1'b0;
      bad_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      i_q <= i_d;
      p_q <= p_d;
      near_q <= near_d;
      found_q <= found_d;
      bad_q <= bad_d;
      best_q <= best_d;
      best_cnt_q <= best_cnt_d;
      label_q <= label_d;
      votes_q <= votes_d;
      empty_q <= empty_d;
      bad_out_q <= bad_out_d;
    end
  end
endmodule
